// File: rtl/sdram_wr_burst_reader.sv
// Drains full bursts from the SDRAM write-path FIFO into the SDRAM controller, one word per beat request.
// Optional handshake timeout: define SDRAM_WR_BURST_TIMEOUT_EN.
module sdram_wr_burst_reader #(
    parameter int                DATA_W      = 16,
    parameter int                CNT_W       = 10,
    parameter int                BURST_LEN   = 8,
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] ADDR_BASE   = '0,
    parameter logic [ADDR_W-1:0] ADDR_END    = 24'hFFFFF8,
    parameter int                TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_ren,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ack,
    input  logic              wr_data_req,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              busy,
    output logic              underflow,
    output logic              timeout_err,
    output logic [1:0]        state_dbg
);

    // Handshakes: wr_req is held until the wr_ack pulse; each wr_data_req beat is
    // answered by a FIFO read whose data appears on wr_data the following cycle.
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_WAIT} state_t;

    localparam logic [CNT_W-1:0]  BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt, addr_adv;
    logic              req_nxt, under_nxt, tmo_nxt;
    logic              accept, ren_raw, tmo_hit;

`ifdef SDRAM_WR_BURST_TIMEOUT_EN
    logic [10:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || state_nxt != state) begin
            tmo_cnt <= '0;
        end else if (state == S_REQ || state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 11'd1;
        end
    end

    assign tmo_hit = (state == S_REQ || state == S_WAIT) &&
                     (tmo_cnt == 11'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Arithmetic wraps modulo 2^ADDR_W; the end compare is exact equality.
    assign addr_adv = (wr_addr == ADDR_END) ? ADDR_BASE : wr_addr + BURST_STEP;

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        addr_nxt     = wr_addr;
        req_nxt      = 1'b0;
        under_nxt    = underflow;
        tmo_nxt      = 1'b0;
        accept       = 1'b0;
        ren_raw      = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_count >= BURST_CNT) state_nxt = S_REQ;
            end
            S_REQ: begin
                req_nxt = 1'b1;
                if (wr_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = S_DATA;
                end else if (tmo_hit) begin
                    req_nxt      = 1'b0;
                    tmo_nxt      = 1'b1;
                    beat_cnt_nxt = '0;
                    state_nxt    = S_IDLE;
                end
            end
            S_DATA: begin
                accept  = wr_data_req && (beat_cnt < BURST_CNT);
                ren_raw = accept && !fifo_empty;
                if (accept) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    if (fifo_empty) under_nxt = 1'b1;
                end
                if (wr_done) begin
                    addr_nxt     = addr_adv;
                    beat_cnt_nxt = '0;
                    state_nxt    = S_IDLE;
                end else if (accept && beat_cnt == BURST_CNT - CNT_W'(1)) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wr_done) begin
                    addr_nxt     = addr_adv;
                    beat_cnt_nxt = '0;
                    state_nxt    = S_IDLE;
                end else if (tmo_hit) begin
                    tmo_nxt      = 1'b1;
                    beat_cnt_nxt = '0;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            wr_addr     <= ADDR_BASE;
            wr_req      <= 1'b0;
            underflow   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            beat_cnt    <= beat_cnt_nxt;
            wr_addr     <= addr_nxt;
            wr_req      <= req_nxt;
            underflow   <= under_nxt;
            timeout_err <= tmo_nxt;
        end
    end

    // A reset cycle must never consume a FIFO word, even if it lands mid-burst.
    assign fifo_ren  = ren_raw && !rst;
    assign wr_data   = fifo_dout;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sdram_wr_burst_reader.sv
// Bench for sdram_wr_burst_reader: behavioural FIFO, expected-data queue, per-scenario tasks.
module tb_sdram_wr_burst_reader;

    localparam int DW = 16;
    localparam int CW = 10;
    localparam int BL = 8;
    localparam int AW = 24;
    localparam int TOUT = 16;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_DATA = 2'd2, ST_WAIT = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_ren;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_ack = 1'b0;
    logic          wr_data_req = 1'b0;
    logic [DW-1:0] wr_data;
    logic          wr_done = 1'b0;
    logic          busy;
    logic          underflow;
    logic          timeout_err;
    logic [1:0]    state_dbg;

    logic [DW-1:0] mem [0:63];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          use_auto = 1'b0;
    logic [CW-1:0] count_force = '0;

    logic [DW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            mdl_beats = 0;
    logic          mdl_under = 1'b0;
    logic [AW-1:0] exp_addr = '0;

    sdram_wr_burst_reader #(
        .DATA_W(DW), .CNT_W(CW), .BURST_LEN(BL), .ADDR_W(AW),
        .ADDR_BASE(24'd0), .ADDR_END(24'd24), .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .fifo_dout(fifo_dout), .fifo_ren(fifo_ren), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_ack(wr_ack), .wr_data_req(wr_data_req), .wr_data(wr_data), .wr_done(wr_done),
        .busy(busy), .underflow(underflow), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // Clock / environment
    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_count = use_auto ? CW'(wr_ptr - rd_ptr) : count_force;

    always @(posedge clk) begin
        if (fifo_ren) begin
            fifo_dout <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(d);
    endtask

    task automatic reset_dut();
        rst = 1'b1; wr_ack = 1'b0; wr_data_req = 1'b0; wr_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        mdl_beats = 0; mdl_under = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (wr_req === 1'b1) begin ok = 1; break; end
            tick();
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s_wait_req: wr_req never rose within 20 cycles", tag); end
    endtask

    task automatic ack_req(input string tag);
        wr_ack = 1'b1; tick(); wr_ack = 1'b0;
        n_checks++;
        if (wr_req !== 1'b0 || state_dbg !== ST_DATA) begin
            n_fail++; $display("FAIL %s_ack: wr_req=%b state=%0d expected 0/%0d", tag, wr_req, state_dbg, ST_DATA);
        end
    endtask

    // Issues n consecutive beat requests; checks fifo_ren per beat and wr_data one cycle later.
    task automatic do_beats(input int n, input string tag);
        logic          exp_ren, pend;
        logic [DW-1:0] exp_d;
        pend = 1'b0; exp_d = '0;
        for (int i = 0; i <= n; i++) begin
            wr_data_req = (i < n);
            #1;
            if (pend) begin
                n_checks++;
                if (wr_data !== exp_d) begin n_fail++; $display("FAIL %s_data[%0d]: wr_data=%h expected %h", tag, i, wr_data, exp_d); end
            end
            exp_ren = (i < n) && (mdl_beats < BL) && !fifo_empty;
            n_checks++;
            if (fifo_ren !== exp_ren) begin n_fail++; $display("FAIL %s_ren[%0d]: fifo_ren=%b expected %b", tag, i, fifo_ren, exp_ren); end
            if (i < n && mdl_beats < BL) begin
                if (fifo_empty) mdl_under = 1'b1;
                mdl_beats++;
            end
            pend = exp_ren;
            if (exp_ren && exp_q.size() > 0) exp_d = exp_q.pop_front();
            @(posedge clk); #1;
        end
        wr_data_req = 1'b0;
    endtask

    task automatic finish_burst(input string tag);
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        exp_addr = (exp_addr == 24'd24) ? 24'd0 : exp_addr + 24'd8;
        mdl_beats = 0;
        n_checks++;
        if (state_dbg !== ST_IDLE || busy !== 1'b0 || wr_addr !== exp_addr) begin
            n_fail++; $display("FAIL %s_done: state=%0d busy=%b wr_addr=%0d expected 0/0/%0d", tag, state_dbg, busy, wr_addr, exp_addr);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        use_auto = 1'b0; count_force = CW'(20);
        rst = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (wr_req !== 0 || fifo_ren !== 0 || busy !== 0 || underflow !== 0 || timeout_err !== 0 || wr_addr !== 0 || state_dbg !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_state: req=%b ren=%b busy=%b uf=%b to=%b addr=%0d st=%0d expected all 0",
                               wr_req, fifo_ren, busy, underflow, timeout_err, wr_addr, state_dbg);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (wr_req !== 1'b0 || state_dbg !== ST_REQ) begin n_fail++; $display("FAIL reset_edge1: wr_req=%b state=%0d expected 0/%0d", wr_req, state_dbg, ST_REQ); end
        tick();
        n_checks++;
        if (wr_req !== 1'b1) begin n_fail++; $display("FAIL reset_edge2: wr_req=%b expected 1", wr_req); end
        count_force = '0;
        reset_dut();
    endtask

    task automatic test_threshold();
        bit seen;
        use_auto = 1'b0; count_force = CW'(BL - 1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (wr_req !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL threshold_below: wr_req/busy rose with count=%0d expected 0", BL - 1); end
        count_force = CW'(BL);
        tick();
        n_checks++;
        if (wr_req !== 1'b0) begin n_fail++; $display("FAIL threshold_edge1: wr_req=%b expected 0", wr_req); end
        tick();
        n_checks++;
        if (wr_req !== 1'b1 || wr_addr !== 24'd0) begin n_fail++; $display("FAIL threshold_edge2: wr_req=%b addr=%0d expected 1/0", wr_req, wr_addr); end
        count_force = '0;
        reset_dut();
    endtask

    task automatic test_full_burst();
        for (int i = 1; i <= BL; i++) push_word(DW'(i));
        use_auto = 1'b1; exp_addr = '0;
        wait_req("burst");
        n_checks++;
        if (wr_addr !== 24'd0) begin n_fail++; $display("FAIL burst_addr: wr_addr=%0d expected 0", wr_addr); end
        ack_req("burst");
        do_beats(BL + 1, "burst");
        n_checks++;
        if (state_dbg !== ST_WAIT || underflow !== 1'b0) begin n_fail++; $display("FAIL burst_wait: state=%0d uf=%b expected %0d/0", state_dbg, underflow, ST_WAIT); end
        finish_burst("burst");
    endtask

    task automatic test_addr_wrap();
        reset_dut();
        use_auto = 1'b1; exp_addr = '0;
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < BL; i++) push_word(DW'($urandom_range(0, 16'hFFFF)));
            wait_req("wrap");
            n_checks++;
            if (wr_addr !== exp_addr) begin n_fail++; $display("FAIL wrap_addr[%0d]: wr_addr=%0d expected %0d", b, wr_addr, exp_addr); end
            ack_req("wrap");
            do_beats(BL, "wrap");
            finish_burst("wrap");
            tick();
        end
    endtask

    task automatic test_underflow();
        reset_dut();
        for (int i = 0; i < 5; i++) push_word(DW'(16'hA0 + i));
        use_auto = 1'b0; count_force = CW'(BL);
        wait_req("uflow");
        count_force = '0;
        ack_req("uflow");
        do_beats(7, "uflow");
        n_checks++;
        if (underflow !== mdl_under || state_dbg !== ST_DATA) begin
            n_fail++; $display("FAIL uflow_set: uf=%b state=%0d expected %b/%0d", underflow, state_dbg, mdl_under, ST_DATA);
        end
        tick(); tick(); tick();
        n_checks++;
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL uflow_sticky: uf=%b expected 1", underflow); end
        push_word(16'h5555);
        rst = 1'b1; wr_data_req = 1'b1;
        #1;
        n_checks++;
        if (fifo_ren !== 1'b0) begin n_fail++; $display("FAIL uflow_rst_ren: fifo_ren=%b expected 0", fifo_ren); end
        tick();
        wr_data_req = 1'b0; rst = 1'b0;
        n_checks++;
        if (state_dbg !== ST_IDLE || underflow !== 1'b0 || wr_addr !== 24'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL uflow_rst: state=%0d uf=%b addr=%0d busy=%b expected 0/0/0/0", state_dbg, underflow, wr_addr, busy);
        end
        exp_q.delete();
    endtask

    task automatic test_timeout();
        bit bad;
        reset_dut();
        use_auto = 1'b0; count_force = CW'(BL);
        tick();
        n_checks++;
        if (state_dbg !== ST_REQ) begin n_fail++; $display("FAIL tmo_enter: state=%0d expected %0d", state_dbg, ST_REQ); end
        bad = 0;
`ifdef SDRAM_WR_BURST_TIMEOUT_EN
        for (int i = 0; i < TOUT - 1; i++) begin
            tick();
            if (timeout_err !== 1'b0 || state_dbg !== ST_REQ) bad = 1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL tmo_early: left REQ or pulsed before cycle %0d", TOUT); end
        tick();
        count_force = '0;
        n_checks++;
        if (timeout_err !== 1'b1 || state_dbg !== ST_IDLE || wr_addr !== 24'd0 || wr_req !== 1'b0) begin
            n_fail++; $display("FAIL tmo_fire: to=%b state=%0d addr=%0d req=%b expected 1/0/0/0", timeout_err, state_dbg, wr_addr, wr_req);
        end
        tick();
        n_checks++;
        if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: timeout_err=%b expected 0", timeout_err); end
`else
        for (int i = 0; i < 99; i++) begin
            tick();
            if (timeout_err !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad || state_dbg !== ST_REQ || wr_req !== 1'b1 || wr_addr !== 24'd0) begin
            n_fail++; $display("FAIL tmo_disabled: to_seen=%b state=%0d req=%b addr=%0d expected 0/%0d/1/0", bad, state_dbg, wr_req, wr_addr, ST_REQ);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_full_burst();
        test_addr_wrap();
        test_underflow();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
